alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that runs 32-bit unsigned multiply and divide on the core's shared single-cycle ALU, one ALU operation per clock. It sits beside the execute stage and drives the ALU's select and operand inputs while busy. The ALU's result is fed back into this block. Requests and responses use a valid/ready handshake.

---
 rtl/alu_muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Multi-cycle sequencer running 32-bit unsigned MUL / DIVU / REMU on the
//   core's shared single-cycle ALU, one ALU operation per clock.
//   Optional build macro: MULDIV_DIV_EN builds the restoring-divide datapath.
//   When it is undefined, ops 01/10 behave like the reserved op 11.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op                 00=MUL, 01=DIVU, 10=REMU, 11=reserved
//   req_a, req_b           multiplicand/dividend, multiplier/divisor
//   rsp_valid/rsp_ready    response handshake (valid only in DONE)
//   rsp_data               result, held stable while in DONE
//   busy                   high in RUN or DONE
//   alu_sel/op0/op1        drive the shared ALU (ADD=0000, SUB=0001)
//   alu_result             combinational ALU result fed back in
module alu_muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int ITERS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_op0,
  output logic [DATA_W-1:0] alu_op1,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [1:0] OP_MUL  = 2'b00;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [3:0] ALU_SUB = 4'b0001;
`endif
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam int         CNT_W   = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;   // multiplicand, or divisor for DIV/REM
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] result;
`ifdef MULDIV_DIV_EN
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;     // starts as the dividend, shifts into quotient
  logic [DATA_W:0]   r33;
  logic              div_ge;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rsp_data_d = rsp_data_q;
    result     = acc_q;
    alu_sel    = ALU_ADD;
    alu_op0    = '0;
    alu_op1    = '0;
`ifdef MULDIV_DIV_EN
    rem_d      = rem_q;
    quot_d     = quot_q;
    r33        = {rem_q, quot_q[DATA_W-1]};
    div_ge     = (r33 >= {1'b0, mcand_q});
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          cnt_d      = '0;
          acc_d      = '0;
          mcand_d    = req_a;
          mplier_d   = req_b;
          rsp_data_d = '0;
`ifdef MULDIV_DIV_EN
          rem_d  = '0;
          quot_d = req_a;
          if (req_op != OP_MUL) mcand_d = req_b;
          state_d = (req_op == OP_MUL || req_op == OP_DIVU || req_op == OP_REMU)
                    ? S_RUN : S_DONE;
`else
          state_d = (req_op == OP_MUL) ? S_RUN : S_DONE;
`endif
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          // Shift-and-add: acc accumulates mcand whenever the current
          // multiplier LSB is set.
          alu_sel  = ALU_ADD;
          alu_op0  = acc_q;
          alu_op1  = mcand_q;
          if (mplier_q[0]) acc_d = alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          result   = acc_d;
        end
`ifdef MULDIV_DIV_EN
        else begin
          // Restoring divide: the 33-bit partial remainder is compared
          // internally, the ALU only forms the 32-bit difference.
          alu_sel = ALU_SUB;
          alu_op0 = r33[DATA_W-1:0];
          alu_op1 = mcand_q;
          rem_d   = div_ge ? alu_result : r33[DATA_W-1:0];
          quot_d  = {quot_q[DATA_W-2:0], div_ge};
          result  = (op_q == OP_DIVU) ? quot_d : rem_d;
        end
`endif
        if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          rsp_data_d = result;
        end
      end

      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rsp_data_q <= '0;
`ifdef MULDIV_DIV_EN
      rem_q      <= '0;
      quot_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rsp_data_q <= rsp_data_d;
`ifdef MULDIV_DIV_EN
      rem_q      <= rem_d;
      quot_q     <= quot_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: directed cases plus randomized requests,
// checked by a scoreboard queue filled on accept and drained by a monitor.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [3:0]  alu_sel;
  logic [31:0] alu_op0;
  logic [31:0] alu_op1;
  logic [31:0] alu_result;

  alu_muldiv_seq #(.DATA_W(32), .ITERS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .alu_sel   (alu_sel),
    .alu_op0   (alu_op0),
    .alu_op1   (alu_op1),
    .alu_result(alu_result)
  );

  // Shared single-cycle ALU
  assign alu_result = (alu_sel == 4'b0000) ? alu_op0 + alu_op1 :
                      (alu_sel == 4'b0001) ? alu_op0 - alu_op1 : 32'hDEADBEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          pend = 0;
  bit          ready_next = 0;
  logic [31:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // Reference model, straight from the arithmetic definitions.
  function automatic logic [31:0] ref_data(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFFFFFF : a / b;
      2'b10:   return !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges from the accepting edge to the edge that raises rsp_valid.
  function automatic int ref_lat(input logic [1:0] op);
    if (op == 2'b00) return 32;
    if ((op == 2'b01 || op == 2'b10) && DIV_EN) return 32;
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept monitor: a request seen valid&&ready at the negedge is taken at
  // the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && req_valid && req_ready) begin
      e.op      = req_op;
      e.data    = ref_data(req_op, req_a, req_b);
      e.lat     = ref_lat(req_op);
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid) begin
        if (!pend) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            held = rsp_data;
            pend = 1;
          end
        end else begin
          chk("rsp_hold", rsp_data, held);
        end
        chk("done_req_ready", {31'd0, req_ready}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_alu_sel", {28'd0, alu_sel}, 32'd0);
        if (rsp_ready) begin
          pend = 0;
          ready_next = 1;
        end
      end else begin
        if (ready_next) chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
        ready_next = 0;
        if (busy) begin
          if (exp_q.size() > 0)
            chk("run_alu_sel", {28'd0, alu_sel}, (exp_q[0].op == 2'b00) ? 32'd0 : 32'd1);
        end else begin
          chk("idle_alu", {28'd0, alu_sel} | alu_op0 | alu_op1, 32'd0);
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int n;
    @(posedge clk); #1;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 80);
    if (!req_ready) fail_now("accept_wait");
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      fail_now("rsp_wait");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      req_valid = $urandom_range(0, 1) == 1;
      req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0] op;
    logic [31:0] a, b;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu", {28'd0, alu_sel} | alu_op0 | alu_op1, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    do_req(2'b00, 32'd7, 32'd6, 0);
    do_req(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_req(2'b01, 32'd100, 32'd7, 0);
    do_req(2'b10, 32'd100, 32'd7, 0);
    do_req(2'b01, 32'd5, 32'd0, 0);
    do_req(2'b10, 32'd5, 32'd0, 0);
    do_req(2'b01, 32'h80000000, 32'd3, 0);
    do_req(2'b00, 32'd3, 32'd5, 10);
    do_req(2'b11, 32'h12345678, 32'h9ABCDEF0, 0);

    // Reset in the middle of a running operation
    @(posedge clk); #1;
    req_op = DIV_EN ? 2'b01 : 2'b00; req_a = 32'd1000; req_b = 32'd9; req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 80);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    chk("abort_alu", {28'd0, alu_sel} | alu_op0 | alu_op1, 32'd0);
    exp_q.delete();
    pend = 0;
    ready_next = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    do_req(2'b00, 32'd2, 32'd3, 0);

    // Randomized requests with random backpressure
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_req(op, a, b, $urandom_range(0, 3));
    end

    // Back-to-back requests with rsp_ready held high
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req_op = (i < 6) ? 2'b11 : 2'($urandom);
      req_a = $urandom; req_b = $urandom_range(0, 100);
      req_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!req_ready && n < 80);
      if (!req_ready) fail_now("burst_accept");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || pend) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("drained", 32'(exp_q.size()), 32'd0);
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
